// File: rtl/spike_enc_pkg.sv
// rtl/spike_enc_pkg.sv - width helpers and field layout for the spike event encoder
package spike_enc_pkg;

  // Neuron id width never collapses to zero, even for a single neuron.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int evt_width(input int id_w, input int ts_w);
    return id_w + ts_w;
  endfunction

  // The id sits directly above the timestamp field in an event word.
  function automatic int id_lsb(input int ts_w);
    return ts_w;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - first-word-fallthrough synchronous FIFO with occupancy count
module sync_fifo
  import spike_enc_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = count_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CW-1:0]    count,
  output logic             full
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             empty;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Head word is shown as zero while empty so the output is clean out of reset.
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/spike_event_encoder.sv
// rtl/spike_event_encoder.sv - spike lines to {neuron_id, timestamp} events over valid/ready
// Timestamp capture is built only when SPIKE_ENC_TIMESTAMP_EN is defined.
module spike_event_encoder
  import spike_enc_pkg::*;
#(
  parameter int N_NEURONS  = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int TS_W       = 8,
  localparam int ID_W      = id_width(N_NEURONS),
  localparam int CNT_W     = count_width(FIFO_DEPTH),
  localparam int EVT_W     = evt_width(ID_W, TS_W)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [N_NEURONS-1:0] spike_in,
  input  logic                 evt_ready,
  output logic                 evt_valid,
  output logic [EVT_W-1:0]     evt_data,
  output logic [CNT_W-1:0]     fifo_count,
  output logic                 overflow
);

  localparam int ID_LSB = id_lsb(TS_W);
`ifdef SPIKE_ENC_TIMESTAMP_EN
  localparam int FIFO_W = EVT_W;
`else
  localparam int FIFO_W = ID_W;
`endif

  logic [N_NEURONS-1:0] pend;
  logic [N_NEURONS-1:0] grant;
  logic [N_NEURONS-1:0] blocked;
  logic [N_NEURONS-1:0] accept;
  logic [N_NEURONS-1:0] drop;
  logic [ID_W-1:0]      win_id;
  logic                 push;
  logic                 pop;
  logic                 fifo_full;
  logic [FIFO_W-1:0]    push_data;
  logic [FIFO_W-1:0]    pop_data;

  // Fixed priority: scanning downwards leaves the lowest pending index as winner.
  always_comb begin
    win_id = '0;
    grant  = '0;
    for (int i = N_NEURONS - 1; i >= 0; i--) begin
      if (pend[i]) win_id = ID_W'(i);
    end
    push = (|pend) && !fifo_full;
    if (push) grant[win_id] = 1'b1;
  end

  assign blocked = pend & ~grant;
  assign accept  = enable ? (spike_in & ~blocked) : '0;
  assign drop    = enable ? (spike_in & blocked) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend     <= '0;
      overflow <= 1'b0;
    end else begin
      pend     <= blocked | accept;
      overflow <= overflow | (|drop);
    end
  end

`ifdef SPIKE_ENC_TIMESTAMP_EN
  logic [TS_W-1:0] ts;
  logic [TS_W-1:0] ts_cap [N_NEURONS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts <= '0;
      for (int i = 0; i < N_NEURONS; i++) ts_cap[i] <= '0;
    end else if (enable) begin
      ts <= ts + TS_W'(1);
      for (int i = 0; i < N_NEURONS; i++) begin
        if (accept[i]) ts_cap[i] <= ts;
      end
    end
  end

  always_comb begin
    push_data                    = '0;
    push_data[ID_LSB +: ID_W]    = win_id;
    push_data[TS_W-1:0]          = ts_cap[win_id];
  end

  always_comb begin
    evt_data = pop_data;
  end
`else
  always_comb begin
    push_data = win_id;
  end

  always_comb begin
    evt_data                  = '0;
    evt_data[ID_LSB +: ID_W]  = pop_data;
  end
`endif

  assign evt_valid = (fifo_count != '0);
  assign pop       = evt_valid && evt_ready;

  sync_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (pop_data),
    .count     (fifo_count),
    .full      (fifo_full)
  );

endmodule

// File: doc/spike_event_encoder.md
# spike_event_encoder

Downstream stage of the LIF neuron array. It samples the per-neuron spike lines every clock and converts each spike into an address-event word {neuron_id, timestamp}. Events are buffered in a small FIFO and presented on a valid/ready output port, so a slow consumer (serial link, readout logic) can drain bursts without losing simultaneous spikes.

## Interface
- N_NEURONS, 4: number of spike inputs; ID_W = clog2(N_NEURONS), minimum 1
- FIFO_DEPTH, 8: event FIFO entries, power of two, ≥2
- TS_W, 8: timestamp counter width
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- enable  in  1  high: capture spikes and advance timestamp
- spike_in  in  N_NEURONS  spike lines from LIF neurons, bit i = neuron i
- evt_ready  in  1  consumer accepts current event
- evt_valid  out  1  event word available
- evt_data  out  ID_W+TS_W  {neuron_id, timestamp}, id in MSBs
- fifo_count  out  clog2(FIFO_DEPTH)+1  FIFO occupancy
- overflow  out  1  sticky: at least one spike dropped

## Operation
- Timestamp counter ts: +1 every clock while enable=1, holds otherwise; wraps modulo 2^TS_W.
- Pending mask pend[N]: on each edge with enable=1, pend ← (pend & ~granted) | spike_in. Each newly set bit latches ts_cap[i] ← ts (value before the increment at that edge).
- Re-spike while pend[i] is set and not granted that cycle: spike dropped, ts_cap[i] unchanged, overflow ← 1.
- Arbiter: fixed priority, lowest set pend index wins. If pend ≠ 0 and FIFO not full, winner {i, ts_cap[i]} is pushed and its pend bit cleared. One push per clock maximum.
- FIFO full: no push; pend held (further spikes merge or overflow per above).
- Full-check uses registered occupancy; no push-bypass on a same-cycle pop.
- Output is first-word-fallthrough: evt_valid = (fifo_count ≠ 0); pop on evt_valid & evt_ready. evt_data stable while evt_valid & ~evt_ready.
- Simultaneous push and pop (FIFO not full): both occur, count unchanged.
- enable=0: no capture, ts holds, pend still drains into FIFO, FIFO still drains to output.
- Reset (any time, incl. mid-burst): ts=0, pend=0, ts_cap=0, FIFO emptied, evt_valid=0, evt_data=0, fifo_count=0, overflow=0. Queued events are discarded.

## Timing
- Spike sampled at edge E → pend set after E → pushed at E+1 (if highest priority and FIFO not full) → evt_valid high after E+1; minimum latency 2 clocks.
- K simultaneous spikes with empty FIFO and evt_ready=1: K events pushed on K consecutive edges, in ascending id order, all with the same timestamp.
- Sustained throughput: one event per clock.
- overflow asserts the clock after the dropping edge and clears only on reset.

## Configuration
- SPIKE_ENC_TIMESTAMP_EN defined: ts counter and ts_cap registers present; timestamp field carries the captured value.
- Not defined: counter and ts_cap removed, timestamp field of evt_data driven 0, FIFO stores ID only (padded on output); port widths unchanged.

## Structure
- Package spike_enc_pkg: ID_W/width helper functions, event field widths, field offsets within evt_data.
- Sub-module sync_fifo (parameterised width/depth, FWFT, count output). Arbiter, pending mask and timestamp logic in the top level.

## Test plan
- Single spike on neuron 2 at ts=5, evt_ready=1 → one event {2, 5}, evt_valid high exactly 2 clocks after sampling, overflow=0.
- spike_in=4'b1111 in one cycle at ts=10 → events {0,10},{1,10},{2,10},{3,10} on consecutive cycles.
- evt_ready=0, 12 spikes on rotating neurons → fifo_count saturates at 8, evt_data held, pend retains excess; release evt_ready → remaining events delivered in order, none lost unless re-spike occurred.
- Neuron 1 spikes twice while its pend bit is blocked by full FIFO → second spike dropped, overflow=1 and stays 1 until reset.
- Run ts to 255 then spike → event carries 255, next spike carries 0 (wrap); rst_n pulsed low with 5 events queued → evt_valid=0, fifo_count=0 immediately, overflow cleared.
- Build without SPIKE_ENC_TIMESTAMP_EN → same id sequence as scenario 2, timestamp field 0.
